// File: rtl/uart_rx_pkt_ctrl.sv
// rtl/uart_rx_pkt_ctrl.sv - packet framer/validator behind the UART receiver
//
// Hunts the receiver byte stream for SYNC|LEN|PAYLOAD|CHK frames, checks LEN,
// the XOR checksum and the inter-byte timeout, buffers the payload and then
// streams it out one byte per handshake.
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   s_ticks       oversample tick shared with the receiver (drives the timeout)
//   rx_done_ticks 1-cycle strobe, rx_dout holds a new byte
//   rx_dout       received byte
//   m_data        payload byte out
//   m_valid       m_data valid
//   m_last        final payload byte of the packet
//   m_ready       downstream accept
//   pkt_len       LEN of the packet being streamed, held until the next one
//   busy          controller is inside a frame or streaming
//   pkt_done      pulse on handshake of the m_last byte
//   err_len       pulse, LEN was 0 or above MAX_LEN
//   err_chk       pulse, checksum mismatch
//   err_timeout   pulse, inter-byte silence reached TIMEOUT_TICKS
//   overrun       pulse, byte arrived while streaming and was dropped

module uart_rx_pkt_ctrl #(
  parameter int               DBITS         = 8,
  parameter logic [DBITS-1:0] SYNC_BYTE     = 8'hA5,
  parameter int               MAX_LEN       = 16,
  parameter int               TIMEOUT_TICKS = 320,
  localparam int              LW            = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_ticks,
  input  logic             rx_done_ticks,
  input  logic [DBITS-1:0] rx_dout,
  output logic [DBITS-1:0] m_data,
  output logic             m_valid,
  output logic             m_last,
  input  logic             m_ready,
  output logic [LW-1:0]    pkt_len,
  output logic             busy,
  output logic             pkt_done,
  output logic             err_len,
  output logic             err_chk,
  output logic             err_timeout,
  output logic             overrun
);

  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_SEND
  } state_t;

  state_t           state;
  logic [LW-1:0]    len;
  logic [DBITS-1:0] chk;
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    rd_idx;
  logic [IW-1:0]    rd_nxt;
  logic [TW-1:0]    tmo_cnt;
  logic [DBITS-1:0] buf_mem [MAX_LEN];

  logic in_frame;
  logic tmo_hit;
  logic len_ok;

  assign in_frame = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHK);
  // A byte on the terminal tick wins: the timeout only fires on a byte-free cycle.
  assign tmo_hit  = in_frame && s_ticks && !rx_done_ticks &&
                    (tmo_cnt == TW'(TIMEOUT_TICKS - 1));
  assign len_ok   = (rx_dout != '0) && (32'(rx_dout) <= 32'(MAX_LEN));
  assign rd_nxt   = rd_idx + IW'(1);

  // Payload buffer has no reset; its contents are only read after a full frame.
  always_ff @(posedge clk) begin
    if (state == S_PAYLOAD && rx_done_ticks) begin
      buf_mem[wr_idx] <= rx_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      len         <= '0;
      chk         <= '0;
      wr_idx      <= '0;
      rd_idx      <= '0;
      tmo_cnt     <= '0;
      m_data      <= '0;
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
      pkt_len     <= '0;
      busy        <= 1'b0;
      pkt_done    <= 1'b0;
      err_len     <= 1'b0;
      err_chk     <= 1'b0;
      err_timeout <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      pkt_done    <= 1'b0;
      err_len     <= 1'b0;
      err_chk     <= 1'b0;
      err_timeout <= 1'b0;
      overrun     <= 1'b0;

      // Outside a frame the counter sits at zero, so entering LEN starts fresh.
      if (in_frame) begin
        if (rx_done_ticks) begin
          tmo_cnt <= '0;
        end else if (s_ticks) begin
          tmo_cnt <= tmo_cnt + TW'(1);
        end
      end else begin
        tmo_cnt <= '0;
      end

      if (tmo_hit) begin
        err_timeout <= 1'b1;
        busy        <= 1'b0;
        state       <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (rx_done_ticks && rx_dout == SYNC_BYTE) begin
              busy  <= 1'b1;
              state <= S_LEN;
            end
          end

          S_LEN: begin
            if (rx_done_ticks) begin
              chk <= rx_dout;
              if (len_ok) begin
                len    <= LW'(rx_dout);
                wr_idx <= '0;
                state  <= S_PAYLOAD;
              end else begin
                err_len <= 1'b1;
                busy    <= 1'b0;
                state   <= S_IDLE;
              end
            end
          end

          S_PAYLOAD: begin
            if (rx_done_ticks) begin
              chk <= chk ^ rx_dout;
              if (LW'(wr_idx) == len - LW'(1)) begin
                state <= S_CHK;
              end else begin
                wr_idx <= wr_idx + IW'(1);
              end
            end
          end

          S_CHK: begin
            if (rx_done_ticks) begin
              if (rx_dout == chk) begin
                rd_idx  <= '0;
                pkt_len <= len;
                m_valid <= 1'b1;
                m_data  <= buf_mem[IW'(0)];
                m_last  <= (len == LW'(1));
                state   <= S_SEND;
              end else begin
                err_chk <= 1'b1;
                busy    <= 1'b0;
                state   <= S_IDLE;
              end
            end
          end

          S_SEND: begin
            if (m_ready) begin
              if (m_last) begin
                m_valid  <= 1'b0;
                m_last   <= 1'b0;
                pkt_done <= 1'b1;
                busy     <= 1'b0;
                state    <= S_IDLE;
              end else begin
                rd_idx <= rd_nxt;
                m_data <= buf_mem[rd_nxt];
                m_last <= (LW'(rd_nxt) == len - LW'(1));
              end
            end
            // A byte landing on the final handshake is dropped quietly so the
            // done pulse never coincides with overrun.
            if (rx_done_ticks && !(m_ready && m_last)) begin
              overrun <= 1'b1;
            end
          end

          default: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
